// File: rtl/csirx_pkg.sv
// Shared definitions for the csirx PPI lane controller.
//   lane_state_e : controller FSM states, encoded 0..4 as published on state_o
//   STATE_W      : width of the state encoding
//   skew_width() : bits needed to hold a skew count in 0..skew_max
package csirx_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_OFF    = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_SYNC   = 3'd3,
      ST_ACTIVE = 3'd4
   } lane_state_e;

   function automatic int skew_width(input int skew_max);
      int w;
      w = $clog2(skew_max + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/csirx_skew_tracker.sv
// Per-burst SoT bookkeeping: which lanes have delivered their SoT and the
// cycle offset of each lane's SoT relative to the first one.
//   clk_i / rst_i   : byte clock, synchronous active-high reset
//   clr_i           : first SoT of a burst; seen := sync_i, those lanes skew 0
//   cap_i           : collecting; lanes newly pulsing get skew := scnt_i
//   sync_i          : per-lane SoT pulses
//   scnt_i          : current skew count to record
//   seen_next_o     : seen mask including this cycle's pulses
//   lane_skew_o     : packed per-lane skew, lane i at [i*SW +: SW]
module csirx_skew_tracker
   import csirx_pkg::*;
#(
   parameter int N_DATA_LANES = 2,
   parameter int SW           = 3
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clr_i,
   input  logic                       cap_i,
   input  logic [N_DATA_LANES-1:0]    sync_i,
   input  logic [SW-1:0]              scnt_i,
   output logic [N_DATA_LANES-1:0]    seen_next_o,
   output logic [N_DATA_LANES*SW-1:0] lane_skew_o
);

   logic [N_DATA_LANES-1:0]    seen_q;
   logic [N_DATA_LANES*SW-1:0] skew_q;

   // Lookahead mask so the FSM can detect completion in the same cycle.
   always_comb begin
      seen_next_o = seen_q | sync_i;
   end

   // Seen mask and skew capture; repeat pulses on a seen lane are ignored.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         seen_q <= '0;
         skew_q <= '0;
      end else if (clr_i) begin
         seen_q <= sync_i;
         for (int i = 0; i < N_DATA_LANES; i++) begin
            if (sync_i[i]) begin
               skew_q[i*SW +: SW] <= '0;
            end
         end
      end else if (cap_i) begin
         seen_q <= seen_q | sync_i;
         for (int i = 0; i < N_DATA_LANES; i++) begin
            if (sync_i[i] && !seen_q[i]) begin
               skew_q[i*SW +: SW] <= scnt_i;
            end
         end
      end
   end

   assign lane_skew_o = skew_q;

endmodule

// File: rtl/csirx_lane_ctrl.sv
// D-PHY PPI lane sequencer: brings up clock/data lanes with forcerxmode,
// waits for LP-11 stop state, then measures per-lane SoT skew each HS burst
// and publishes the result with a one-cycle align pulse.
//   rxbyteclkhs_i / rxbyteclkhs_reset_i : byte clock, sync active-high reset
//   ctrl_enable_i                       : software enable, low forces OFF
//   cl_stopstate_i / dl_stopstate_i     : lanes in LP-11
//   dl_rxactivehs_i / dl_rxsynchs_i     : per-lane HS active and SoT pulse
//   err_clr_i                           : clears sticky err_skew_o
//   cl_enable_o, dl_enable_o, dl_forcerxmode_o : PPI lane controls
//   lane_skew_o, align_valid_o, pkt_active_o   : to lane-merge datapath
//   err_skew_o, state_o                        : status
module csirx_lane_ctrl
   import csirx_pkg::*;
#(
   parameter int N_DATA_LANES   = 2,
   parameter int FORCERX_CYCLES = 16,
   parameter int SKEW_MAX       = 4
) (
   input  logic                                          rxbyteclkhs_i,
   input  logic                                          rxbyteclkhs_reset_i,
   input  logic                                          ctrl_enable_i,
   input  logic                                          cl_stopstate_i,
   input  logic [N_DATA_LANES-1:0]                       dl_stopstate_i,
   input  logic [N_DATA_LANES-1:0]                       dl_rxactivehs_i,
   input  logic [N_DATA_LANES-1:0]                       dl_rxsynchs_i,
   input  logic                                          err_clr_i,
   output logic                                          cl_enable_o,
   output logic [N_DATA_LANES-1:0]                       dl_enable_o,
   output logic [N_DATA_LANES-1:0]                       dl_forcerxmode_o,
   output logic [N_DATA_LANES*skew_width(SKEW_MAX)-1:0]  lane_skew_o,
   output logic                                          align_valid_o,
   output logic                                          pkt_active_o,
   output logic                                          err_skew_o,
   output logic [STATE_W-1:0]                            state_o
);

   localparam int SW    = skew_width(SKEW_MAX);
   localparam int CNT_W = (FORCERX_CYCLES > 1) ? $clog2(FORCERX_CYCLES) : 1;
   localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(FORCERX_CYCLES - 1);
   localparam logic [SW-1:0]           SKEW_LAST = SW'(SKEW_MAX);
   localparam logic [N_DATA_LANES-1:0] ALL_LANES = {N_DATA_LANES{1'b1}};

   lane_state_e             state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [SW-1:0]           scnt_q, scnt_d, scnt_cur_s;
   logic                    trk_clr_s, trk_cap_s, err_set_s;
   logic [N_DATA_LANES-1:0] seen_next_s;

   logic                    cl_enable_q, align_valid_q, pkt_active_q, err_skew_q;
   logic [N_DATA_LANES-1:0] dl_enable_q, dl_forcerxmode_q;

   // scnt_q holds the previous SYNC count; the first SYNC cycle counts as 1.
   assign scnt_cur_s = scnt_q + SW'(1);

   csirx_skew_tracker #(
      .N_DATA_LANES (N_DATA_LANES),
      .SW           (SW)
   ) u_skew_tracker (
      .clk_i       (rxbyteclkhs_i),
      .rst_i       (rxbyteclkhs_reset_i),
      .clr_i       (trk_clr_s),
      .cap_i       (trk_cap_s),
      .sync_i      (dl_rxsynchs_i),
      .scnt_i      (scnt_cur_s),
      .seen_next_o (seen_next_s),
      .lane_skew_o (lane_skew_o)
   );

   // Next-state logic with tracker strobes; disable overrides every transition.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      scnt_d    = scnt_q;
      trk_clr_s = 1'b0;
      trk_cap_s = 1'b0;
      err_set_s = 1'b0;
      if (!ctrl_enable_i) begin
         state_d = ST_OFF;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d = ST_INIT;
               cnt_d   = '0;
            end
            ST_INIT: begin
               if (cnt_q != CNT_LAST) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  cnt_d = cnt_q;
               end
               if ((cnt_q == CNT_LAST) && cl_stopstate_i && (&dl_stopstate_i)) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_INIT;
               end
            end
            ST_IDLE: begin
               if (|dl_rxsynchs_i) begin
                  trk_clr_s = 1'b1;
                  scnt_d    = '0;
                  state_d   = (dl_rxsynchs_i == ALL_LANES) ? ST_ACTIVE : ST_SYNC;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_SYNC: begin
               trk_cap_s = 1'b1;
               scnt_d    = scnt_cur_s;
               // Completion this cycle wins over abort/timeout.
               if (seen_next_s == ALL_LANES) begin
                  state_d = ST_ACTIVE;
               end else if (~|dl_rxactivehs_i) begin
                  state_d   = ST_IDLE;
                  err_set_s = 1'b1;
               end else if (scnt_cur_s == SKEW_LAST) begin
                  state_d   = ST_IDLE;
                  err_set_s = 1'b1;
               end else begin
                  state_d = ST_SYNC;
               end
            end
            ST_ACTIVE: begin
               if (~|dl_rxactivehs_i) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_ACTIVE;
               end
            end
            default: begin
               state_d = ST_OFF;
            end
         endcase
      end
   end

   // State, counters, sticky error and Moore outputs decoded from next state.
   always_ff @(posedge rxbyteclkhs_i) begin
      if (rxbyteclkhs_reset_i) begin
         state_q          <= ST_OFF;
         cnt_q            <= '0;
         scnt_q           <= '0;
         err_skew_q       <= 1'b0;
         cl_enable_q      <= 1'b0;
         dl_enable_q      <= '0;
         dl_forcerxmode_q <= '0;
         align_valid_q    <= 1'b0;
         pkt_active_q     <= 1'b0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         scnt_q           <= scnt_d;
         err_skew_q       <= err_set_s ? 1'b1 : (err_clr_i ? 1'b0 : err_skew_q);
         cl_enable_q      <= (state_d != ST_OFF);
         dl_enable_q      <= (state_d != ST_OFF) ? ALL_LANES : '0;
         dl_forcerxmode_q <= (state_d == ST_INIT) ? ALL_LANES : '0;
         align_valid_q    <= (state_d == ST_ACTIVE) && (state_q != ST_ACTIVE);
         pkt_active_q     <= (state_d == ST_ACTIVE);
      end
   end

   assign cl_enable_o      = cl_enable_q;
   assign dl_enable_o      = dl_enable_q;
   assign dl_forcerxmode_o = dl_forcerxmode_q;
   assign align_valid_o    = align_valid_q;
   assign pkt_active_o     = pkt_active_q;
   assign err_skew_o       = err_skew_q;
   assign state_o          = state_q;

endmodule
